uart_cmd_ctrl: RTL
==================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 rx_fifo_empty  input  1  RX FIFO empty flag.
REQ-005 rx_fifo_rdata  input  8  RX FIFO head byte (first-word-fall-through), valid while rx_fifo_empty=0.
REQ-006 rx_fifo_pop  output  1  one-cycle RX FIFO pop strobe.
REQ-007 tx_fifo_full  input  1  TX FIFO full flag.
REQ-008 tx_fifo_push  output  1  one-cycle TX FIFO push strobe.
REQ-009 tx_fifo_wdata  output  8  TX FIFO write byte, valid when tx_fifo_push=1.
REQ-010 btn_run, btn_clear, btn_mode  input  1 each  one-cycle button request pulses from the debouncer.
REQ-011 cmd_run, cmd_clear, cmd_mode  output  1 each  one-cycle command pulses to the downstream core.
REQ-012 err_cnt  output  8  saturating count of unrecognised RX bytes.

Function
REQ-013 FSM states SHALL be IDLE, EXEC and ECHO.
REQ-014 IDLE: when rx_fifo_empty=0, latch rx_fifo_rdata into byte_reg and go to EXEC; otherwise stay in IDLE.
REQ-015 EXEC: rx_fifo_pop=1 for exactly this one cycle; decode byte_reg and go to ECHO.
REQ-016 Decode: 0x72/0x52 ('r'/'R') -> run; 0x63/0x43 ('c'/'C') -> clear; 0x6D/0x4D ('m'/'M') -> mode; any other value -> unknown.
REQ-017 The UART command pulse SHALL be registered: a byte latched at edge N produces cmd_* high for the single cycle following EXEC (latency 2 cycles from latch).
REQ-018 An unknown byte SHALL increment err_cnt once, saturating at 0xFF, and generate no cmd_* pulse.
REQ-019 ECHO: while tx_fifo_full=1, wait with tx_fifo_push=0; on the first cycle tx_fifo_full=0, push exactly once and return to IDLE.
REQ-020 Echo data: for a recognised byte, tx_fifo_wdata SHALL equal byte_reg; for an unknown byte, it SHALL be 0x3F ('?').
REQ-021 Throughput: at most one byte per 3 cycles, and no new byte is latched until ECHO completes.
REQ-022 Each cmd_* output SHALL be the OR of its button pulse and its UART pulse. A coincident button and UART request on the same output produces one pulse, not two.
REQ-023 Clear priority: in any cycle where cmd_clear=1, cmd_run and cmd_mode SHALL be 0. Suppressed requests are dropped, not deferred.
REQ-024 Button pulses SHALL pass to cmd_* with 1-cycle registered latency in every FSM state, including during ECHO stalls.
REQ-025 rx_fifo_pop and tx_fifo_push SHALL never be high in the same cycle.

Reset
REQ-026 When rst=1 at a clock edge, the FSM SHALL go to IDLE, and rx_fifo_pop, tx_fifo_push, all cmd_* outputs, tx_fifo_wdata, byte_reg and err_cnt SHALL all become 0.
REQ-027 Reset in EXEC or ECHO SHALL abandon the in-flight byte, with no pop and no push afterwards. A byte already popped is lost, and this is accepted.
REQ-028 Button pulses present during reset SHALL be ignored.

Structure
REQ-029 Package uart_cmd_pkg SHALL hold the character constants (0x72, 0x52, 0x63, 0x43, 0x6D, 0x4D, 0x3F) and the FSM state encoding.
REQ-030 Byte classification SHALL live in one combinational sub-module, uart_cmd_decode (8-bit byte in; run/clear/mode/unknown one-hot out). The FSM, arbitration and counter stay in uart_cmd_ctrl.

Verification
REQ-031 RX FIFO holds 0x72 and TX is not full -> one pop, then cmd_run for one cycle, then a push of 0x72; err_cnt stays 0.
REQ-032 RX FIFO holds 0x41 -> no cmd_* pulse; a push of 0x3F; err_cnt goes from 0 to 1. Then 256 further 0x41 bytes -> err_cnt holds at 0xFF.
REQ-033 RX 0x6D with tx_fifo_full=1 for 10 cycles -> no push during the stall; exactly one push of 0x6D in the first cycle full=0; no pop of the next byte before that push.
REQ-034 btn_clear aligned with the UART cmd_run pulse from 0x52 -> cmd_clear=1 and cmd_run=0 in that cycle; the echo of 0x52 still occurs.
REQ-035 btn_mode coincident with the UART mode pulse from 0x4D -> exactly one cmd_mode cycle.
REQ-036 rst asserted during ECHO with tx_fifo_full=1 -> FSM returns to IDLE, no push ever occurs for that byte, all outputs are 0, and the next RX byte is processed normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command controller: recognised command
// characters, the echo substitute for unknown bytes, the FSM state encoding
// and the per-command request bundle.
package uart_cmd_pkg;

  localparam logic [7:0] CH_RUN_LO  = 8'h72;  // 'r'
  localparam logic [7:0] CH_RUN_UP  = 8'h52;  // 'R'
  localparam logic [7:0] CH_CLR_LO  = 8'h63;  // 'c'
  localparam logic [7:0] CH_CLR_UP  = 8'h43;  // 'C'
  localparam logic [7:0] CH_MODE_LO = 8'h6D;  // 'm'
  localparam logic [7:0] CH_MODE_UP = 8'h4D;  // 'M'
  localparam logic [7:0] CH_UNKNOWN = 8'h3F;  // '?'

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_ECHO = 2'd2;

  typedef struct packed {
    logic run;
    logic clear;
    logic mode;
  } cmd_t;

endpackage

// File: rtl/uart_cmd_if.sv
// RX/TX FIFO handshake bundle between the command controller (master) and
// the UART FIFOs (slave).
interface uart_cmd_if;

  logic       rx_fifo_empty;
  logic [7:0] rx_fifo_rdata;
  logic       rx_fifo_pop;
  logic       tx_fifo_full;
  logic       tx_fifo_push;
  logic [7:0] tx_fifo_wdata;

  modport master (
    input  rx_fifo_empty, rx_fifo_rdata, tx_fifo_full,
    output rx_fifo_pop, tx_fifo_push, tx_fifo_wdata
  );

  modport slave (
    output rx_fifo_empty, rx_fifo_rdata, tx_fifo_full,
    input  rx_fifo_pop, tx_fifo_push, tx_fifo_wdata
  );

endinterface

// File: rtl/uart_cmd_decode.sv
// Combinational classifier for one received byte: exactly one of
// run/clear/mode/unknown is high for any input value.
module uart_cmd_decode
  import uart_cmd_pkg::*;
(
  input  logic [7:0] data,
  output logic       run,
  output logic       clear,
  output logic       mode,
  output logic       unknown
);

  // Map the upper- and lower-case command letters to their command class.
  always_comb begin
    // NOTE: every output gets a value before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    run     = 1'b0;
    clear   = 1'b0;
    mode    = 1'b0;
    unknown = 1'b0;
    case (data)
      CH_RUN_LO,  CH_RUN_UP:  run   = 1'b1;
      CH_CLR_LO,  CH_CLR_UP:  clear = 1'b1;
      CH_MODE_LO, CH_MODE_UP: mode  = 1'b1;
      default:                unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: takes bytes from the RX FIFO, turns recognised
// letters into one-cycle command pulses (merged with button pulses, clear
// having priority), counts unknown bytes and echoes every byte to the TX FIFO.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  uart_cmd_if.master       fifo,
  input  logic             btn_run,
  input  logic             btn_clear,
  input  logic             btn_mode,
  output logic             cmd_run,
  output logic             cmd_clear,
  output logic             cmd_mode,
  output logic [7:0]       err_cnt
);

  logic [1:0] state;
  logic [7:0] byte_reg;
  logic [7:0] echo_data;
  logic       dec_run, dec_clear, dec_mode, dec_unknown;
  logic       in_exec;
  cmd_t       req, cmd_next;

  uart_cmd_decode u_decode (
    .data    (byte_reg),
    .run     (dec_run),
    .clear   (dec_clear),
    .mode    (dec_mode),
    .unknown (dec_unknown)
  );

  assign in_exec            = (state == ST_EXEC);
  assign fifo.rx_fifo_pop   = in_exec;
  assign fifo.tx_fifo_push  = (state == ST_ECHO) && !fifo.tx_fifo_full;
  assign fifo.tx_fifo_wdata = echo_data;

  // Merge button and UART requests, then let clear suppress run and mode.
  always_comb begin
    req.run   = btn_run   | (in_exec & dec_run);
    req.clear = btn_clear | (in_exec & dec_clear);
    req.mode  = btn_mode  | (in_exec & dec_mode);
    cmd_next  = req;
    if (req.clear) begin
      cmd_next.run  = 1'b0;
      cmd_next.mode = 1'b0;
    end
  end

  // Byte sequencing: latch in IDLE, pop and decode in EXEC, echo in ECHO.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      byte_reg  <= 8'h00;
      echo_data <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo.rx_fifo_empty) begin
            byte_reg <= fifo.rx_fifo_rdata;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          echo_data <= dec_unknown ? CH_UNKNOWN : byte_reg;
          state     <= ST_ECHO;
        end
        ST_ECHO: begin
          if (!fifo.tx_fifo_full) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered command pulses; buttons seen during reset are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_run   <= 1'b0;
      cmd_clear <= 1'b0;
      cmd_mode  <= 1'b0;
    end else begin
      cmd_run   <= cmd_next.run;
      cmd_clear <= cmd_next.clear;
      cmd_mode  <= cmd_next.mode;
    end
  end

  // Saturating count of unrecognised bytes, bumped once per decoded byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= 8'h00;
    end else if (in_exec && dec_unknown && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule
